// File: rtl/buf_inv_pipe_pkg.sv
// buf_inv_pipe_pkg: lane packing and occupancy-width helpers for buf_inv_pipe.
package buf_inv_pipe_pkg;
  function automatic int lane_lsb(input int c, input int width);
    return c * width;
  endfunction
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/buf_inv_stage.sv
// buf_inv_stage: one valid/ready register stage with synchronous flush.
module buf_inv_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= flush ? 1'b0 : (in_ready ? in_valid : out_valid);
      if (in_valid && in_ready) out_data <= in_data;
    end
  end
endmodule

// File: rtl/buf_inv_pipe.sv
// buf_inv_pipe: CHANNELS independent DEPTH-stage valid/ready lanes with entry inversion.
// Define BUF_INV_PIPE_OCC_EN to add the per-lane occupancy output occ.
module buf_inv_pipe
  import buf_inv_pipe_pkg::*;
#(
  parameter int                  WIDTH    = 8,
  parameter int                  DEPTH    = 2,
  parameter int                  CHANNELS = 2,
  parameter logic [CHANNELS-1:0] INV_MASK = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_and
`ifdef BUF_INV_PIPE_OCC_EN
  ,
  output logic [CHANNELS*occ_w(DEPTH)-1:0] occ
`endif
);
  localparam int OW = occ_w(DEPTH);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic             v [DEPTH+1];
    logic             r [DEPTH+1];
    logic [WIDTH-1:0] d [DEPTH+1];
    assign v[0] = in_valid[c];
    assign d[0] = in_data[lane_lsb(c, WIDTH) +: WIDTH] ^ {WIDTH{INV_MASK[c]}};
    assign r[DEPTH] = out_ready[c];
    assign in_ready[c] = r[0];
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      buf_inv_stage #(.WIDTH(WIDTH)) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (v[k]),
        .in_ready  (r[k]),
        .in_data   (d[k]),
        .out_valid (v[k+1]),
        .out_ready (r[k+1]),
        .out_data  (d[k+1])
      );
    end
    assign out_valid[c] = v[DEPTH];
    assign out_data[lane_lsb(c, WIDTH) +: WIDTH] = d[DEPTH];
    assign out_and[c] = v[DEPTH] && (&d[DEPTH]);
`ifdef BUF_INV_PIPE_OCC_EN
    // counter tracks words in flight: +1 on accept, -1 on emit
    logic [OW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else cnt <= flush ? '0 : cnt + OW'(v[0] && r[0]) - OW'(v[DEPTH] && r[DEPTH]);
    end
    assign occ[c*OW +: OW] = cnt;
`endif
  end
endmodule

// File: tb/tb_buf_inv_pipe.sv
// tb_buf_inv_pipe: randomized scoreboard bench plus directed latency/stall/flush/reset checks.
module tb_buf_inv_pipe;
  localparam int W = 8, D = 3, C = 2;
  localparam logic [C-1:0] MASK = 2'b01;
  logic clk = 0, rst_n = 0, flush = 0;
  logic [C-1:0] in_valid = '0, in_ready, out_valid, out_ready = '0, out_and;
  logic [C*W-1:0] in_data = '0, out_data;
`ifdef BUF_INV_PIPE_OCC_EN
  localparam int OW = $clog2(D + 1);
  logic [C*OW-1:0] occ;
`endif
  int checks = 0, errors = 0;
  logic [W-1:0] sb [C][$];

  buf_inv_pipe #(.WIDTH(W), .DEPTH(D), .CHANNELS(C), .INV_MASK(MASK)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_and(out_and)
`ifdef BUF_INV_PIPE_OCC_EN
    , .occ(occ)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: the reference model is one queue of words in flight per lane.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < C; c++) begin
        logic [W-1:0] od;
        od = out_data[c*W +: W];
        chk("in_ready", in_ready[c], !(sb[c].size() == D && !out_ready[c]));
        chk("out_and", out_and[c], out_valid[c] && (&od));
`ifdef BUF_INV_PIPE_OCC_EN
        chk("occ", occ[c*OW +: OW], sb[c].size());
`endif
        if (out_valid[c] && out_ready[c]) begin
          if (sb[c].size() == 0) chk("spurious_out", out_valid[c], 0);
          else chk("out_data", od, sb[c].pop_front());
        end
        if (flush) sb[c].delete();
        else if (in_valid[c] && in_ready[c]) sb[c].push_back(in_data[c*W +: W] ^ {W{MASK[c]}});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_and", out_and, 0);
    chk("rst_in_ready", in_ready, 2'b11);
    for (int c = 0; c < C; c++) sb[c].delete();
    in_valid = '0;
    @(posedge clk);
    #3 rst_n = 1;
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1);
      in_valid = C'($urandom_range(0, 3));
      in_data = (C*W)'($urandom);
      out_ready = C'($urandom_range(0, 3));
      flush = ($urandom_range(0, 49) == 0);
    end
    cyc(1);
    flush = 0;
    in_valid = '0;
  endtask

  initial begin
    #12;
    chk("init_out_valid", out_valid, 0);
    chk("init_out_data", out_data, 0);
    chk("init_in_ready", in_ready, 2'b11);
    @(posedge clk);
    #3 rst_n = 1;
    out_ready = 2'b11;
    // latency and inversion on lane 0
    cyc(1);
    in_valid = 2'b01;
    in_data = 16'h005A;
    cyc(1);
    in_valid = '0;
    chk("lat_e1", out_valid[0], 0);
    cyc(1);
    chk("lat_e2", out_valid[0], 0);
    cyc(1);
    chk("lat_e3", out_valid[0], 1);
    chk("lat_data", out_data[7:0], 8'hA5);
    cyc(3);
    // all-ones outputs
    in_valid = 2'b11;
    in_data = 16'hFF00;
    cyc(1);
    in_valid = '0;
    cyc(2);
    chk("ones_data", out_data, 16'hFFFF);
    chk("ones_and", out_and, 2'b11);
    cyc(3);
    // lane 1 stall while lane 0 streams
    out_ready = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 2'b11;
      in_data = {8'(i), 8'($urandom)};
      if (i == 4) chk("stall_in_ready", in_ready[1], 0);
      cyc(1);
    end
    in_data[7:0] = 8'h3C;
    cyc(1);
    chk("stall_hold_v", out_valid[1], 1);
    chk("stall_hold_d", out_data[15:8], 8'h01);
    out_ready = 2'b11;
    #1 chk("ripple_in_ready", in_ready[1], 1);
    cyc(1);
    in_valid = '0;
    cyc(5);
    // full lane streaming without bubbles
    out_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      in_valid = 2'b10;
      in_data = {8'(8'h10 + i), 8'h00};
      cyc(1);
    end
    out_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      in_data = {8'(8'h20 + i), 8'h00};
      #1;
      chk("stream_in_ready", in_ready[1], 1);
      chk("stream_out_valid", out_valid[1], 1);
      cyc(1);
    end
    in_valid = '0;
    cyc(5);
    // flush with two words in flight
    out_ready = 2'b00;
    in_valid = 2'b11;
    in_data = 16'h1234;
    cyc(1);
    in_data = 16'h5678;
    cyc(1);
    flush = 1;
    in_data = 16'h9ABC;
    cyc(1);
    flush = 0;
    in_valid = '0;
    chk("flush_out_valid", out_valid, 0);
`ifdef BUF_INV_PIPE_OCC_EN
    chk("flush_occ", occ, 0);
`endif
    out_ready = 2'b11;
    cyc(5);
    // randomized traffic with an asynchronous reset mid-stream
    random_run(300);
    in_valid = 2'b11;
    in_data = 16'hA1B2;
    #1 do_reset();
    random_run(300);
    out_ready = 2'b11;
    for (int i = 0; i < 50 && (sb[0].size() + sb[1].size()) != 0; i++) cyc(1);
    chk("drain_lane0", sb[0].size(), 0);
    chk("drain_lane1", sb[1].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/buf_inv_pipe.md
BUF_INV_PIPE -- requirements
Module: buf_inv_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, register stages per channel (>=1).
REQ-003 SHALL have parameter CHANNELS, default 2, number of independent lanes (>=1).
REQ-004 SHALL have parameter INV_MASK, default all-zero, CHANNELS bits; bit c set inverts lane c at entry.
REQ-005 SHALL have ports clk  input  1  sole clock, all state rising-edge.
REQ-006 SHALL have ports rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports flush  input  1  synchronous clear of all lanes.
REQ-008 SHALL have ports in_valid  input  CHANNELS  per-lane source valid.
REQ-009 SHALL have ports in_ready  output  CHANNELS  per-lane accept.
REQ-010 SHALL have ports in_data  input  CHANNELS*WIDTH  lane c at bits [c*WIDTH +: WIDTH].
REQ-011 SHALL have ports out_valid  output  CHANNELS  per-lane sink valid.
REQ-012 SHALL have ports out_ready  input  CHANNELS  per-lane sink accept.
REQ-013 SHALL have ports out_data  output  CHANNELS*WIDTH  same packing as in_data.
REQ-014 SHALL have ports out_and  output  CHANNELS  lane c: out_valid[c] AND all bits of out_data lane c.

Function
REQ-015 Each lane SHALL be a DEPTH-stage valid/ready pipeline, lanes fully independent.
REQ-016 Entry data SHALL be in_data lane XOR {WIDTH{INV_MASK[c]}}; stored, forwarded, output unchanged thereafter.
REQ-017 Transfer SHALL occur at a port when valid and ready are both high at the rising edge.
REQ-018 Stage k ready SHALL be (!valid_k || ready_{k+1}); last stage uses out_ready; in_ready = stage-0 ready.
REQ-019 Unstalled latency SHALL be exactly DEPTH cycles from input transfer to out_valid high; throughput 1 word/cycle/lane.
REQ-020 A stalled lane SHALL hold out_data and out_valid stable until out_ready; no word dropped or duplicated.
REQ-021 Full lane (all stages valid, out_ready low) SHALL drive in_ready low combinationally.
REQ-022 Simultaneous output transfer and input transfer on a full lane SHALL be accepted same cycle (ready ripples).
REQ-023 flush high at an edge SHALL clear every stage valid of every lane, ignore in_valid that cycle, data registers may keep value.
REQ-024 out_and SHALL be combinational from registered stage outputs only (no in_* to out_and path).

Reset
REQ-025 rst_n low SHALL immediately clear all valid bits: out_valid=0, out_and=0, in_ready=all ones.
REQ-026 Data registers SHALL reset to zero; out_data=0 during reset.
REQ-027 Reset mid-transfer SHALL discard all in-flight words; first word after release exits DEPTH cycles after its acceptance.

Configuration
REQ-028 Macro BUF_INV_PIPE_OCC_EN SHALL, when defined, add output occ  CHANNELS*$clog2(DEPTH+1)  per-lane count of valid stages, registered, reset 0, cleared by flush.
REQ-029 Without BUF_INV_PIPE_OCC_EN, port occ and its counters SHALL not exist; all other behaviour identical.

Structure
REQ-030 Package buf_inv_pipe_pkg SHALL hold lane-index/packing helper function and occupancy-width constant function.
REQ-031 One sub-module buf_inv_stage (single valid/ready register stage, WIDTH param) SHALL be instantiated DEPTH x CHANNELS times via generate.
REQ-032 No latches; no combinational path from in_data to out_data.

Verification (WIDTH=8, DEPTH=3, CHANNELS=2, INV_MASK=2'b01)
REQ-033 Lane0 in 8'h5A, out_ready=1 -> out_data lane0 = 8'hA5, out_valid[0] rises exactly 3 cycles later.
REQ-034 Lane1 in 8'hFF, out_ready=1 -> out_data lane1 = 8'hFF, out_and[1]=1; lane0 in 8'h00 -> 8'hFF, out_and[0]=1.
REQ-035 Lane1 out_ready=0, push 4 words 1,2,3,4 -> 3 accepted, in_ready[1]=0 on 4th; release -> 1,2,3 out in order, then 4; lane0 unaffected streaming.
REQ-036 Full lane with out_ready=1 and in_valid=1 every cycle -> one word in and one out per cycle, no bubbles.
REQ-037 flush with 2 words in flight -> next cycle out_valid=0, occ=0 (if OCC_EN), no flushed word appears.
REQ-038 rst_n low mid-stream, asynchronously -> out_valid=0, out_data=0 before next edge; post-release stream correct.
